// File: rtl/eightby3_enc_seq.sv
// Sequential 8-to-3 encoder: accepts an 8-bit vector and emits one beat per set bit, in priority order.
// Optional build macro ENC_MSB_FIRST_EN drains from bit 7 down to 0 instead of 0 up to 7.
module eightby3_enc_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] inp,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       last,
    output logic       zero
);

    localparam logic StIdle = 1'b0;
    localparam logic StEmit = 1'b1;

    logic       state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [2:0] y_q, y_d;
    logic       last_q, last_d;
    logic       zero_q, zero_d;
    logic       out_valid_q, out_valid_d;

    logic [7:0] sel_vec;
    logic [2:0] sel_idx;
    logic [7:0] sel_rest;

    // Index of the first-priority set bit; 0 when the vector is empty.
    function automatic logic [2:0] first_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
`endif
        return idx;
    endfunction

    // The same picker serves capture in IDLE and draining in EMIT.
    assign sel_vec  = (state_q == StIdle) ? inp : pending_q;
    assign sel_idx  = first_idx(sel_vec);
    assign sel_rest = sel_vec & ~(8'b1 << sel_idx);

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        y_d         = y_q;
        last_d      = last_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    y_d         = sel_idx;
                    pending_d   = sel_rest;
                    last_d      = (sel_rest == 8'd0);
                    zero_d      = (inp == 8'd0);
                    out_valid_d = 1'b1;
                    state_d     = StEmit;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    if (last_q) begin
                        out_valid_d = 1'b0;
                        zero_d      = 1'b0;
                        last_d      = 1'b0;
                        state_d     = StIdle;
                    end else begin
                        y_d       = sel_idx;
                        pending_d = sel_rest;
                        last_d    = (sel_rest == 8'd0);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pending_q   <= 8'd0;
            y_q         <= 3'd0;
            last_q      <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            y_q         <= y_d;
            last_q      <= last_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Gated by rst_n so upstream sees no readiness while reset is held.
    assign in_ready  = (state_q == StIdle) && rst_n;
    assign y         = y_q;
    assign last      = last_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule
